// File: rtl/xgmii_rx_frame_checker_pkg.sv
// Shared definitions for the XGMII receive frame checker: control characters,
// FSM state encoding, the length type and a saturating length adder.
package xgmii_rx_frame_checker_pkg;

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;
  localparam logic [7:0] CH_IDLE  = 8'h07;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_e;

  typedef logic [15:0] len_t;

  function automatic len_t sat_add(input len_t a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_rx_frame_checker_lane_scan.sv
// Combinational scan of one XGMII word: lowest control lane and the
// start/terminate qualifiers the frame FSM needs.
module xgmii_lane_scan
  import xgmii_rx_frame_checker_pkg::*;
(
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic        any_ctrl,
  output logic [2:0]  first_lane,
  output logic        is_term,
  output logic        start_l0,
  output logic        start_l4
);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    first_lane = '0;
    for (int i = 7; i >= 0; i--) begin
      if (xgmii_rxc[i]) first_lane = 3'(i);
    end
    any_ctrl = |xgmii_rxc;
    is_term  = any_ctrl && (xgmii_rxd[{first_lane, 3'b000} +: 8] == CH_TERM);
    start_l0 = xgmii_rxc[0] && (xgmii_rxd[7:0] == CH_START);
    start_l4 = xgmii_rxc[4] && (xgmii_rxd[39:32] == CH_START) && (&xgmii_rxc[3:0]);
  end

endmodule

// File: rtl/xgmii_rx_frame_checker.sv
// Passive XGMII rx frame checker: delimits frames, measures length, classifies
// each frame and keeps saturating statistics counters.
module xgmii_rx_frame_checker
  import xgmii_rx_frame_checker_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  input  logic                   clear,
  output logic                   frame_valid,
  output logic [15:0]            frame_len,
  output logic                   frame_error,
  output logic                   frame_runt,
  output logic                   frame_long,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] good_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] runt_count,
  output logic [COUNT_WIDTH-1:0] long_count
);

  logic       any_ctrl, is_term, start_l0, start_l4;
  logic [2:0] first_lane;

  xgmii_lane_scan u_scan (
    .xgmii_rxd  (xgmii_rxd),
    .xgmii_rxc  (xgmii_rxc),
    .any_ctrl   (any_ctrl),
    .first_lane (first_lane),
    .is_term    (is_term),
    .start_l0   (start_l0),
    .start_l4   (start_l4)
  );

  state_e state_q, state_d;
  len_t   cnt_q, cnt_d, rep_cnt, len_d;
  logic   report, err_d, runt_d, long_d, restart;
  logic [3:0] low_mask;

  logic       valid_q, err_q, runt_q, long_q;
  len_t       len_q;
  logic [4:0] inc;
  logic [COUNT_WIDTH-1:0] stat_q [5];

  // A lane-4 START may follow the ending lane only if lanes up to 3 are all control.
  always_comb begin
    case (first_lane[1:0])
      2'd0:    low_mask = 4'b0000;
      2'd1:    low_mask = 4'b0001;
      2'd2:    low_mask = 4'b0011;
      default: low_mask = 4'b0111;
    endcase
    restart = !first_lane[2] && xgmii_rxc[4] && (xgmii_rxd[39:32] == CH_START) &&
              ((xgmii_rxc[3:0] | low_mask) == 4'hF);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    report  = 1'b0;
    err_d   = 1'b0;
    rep_cnt = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_l0) begin
          state_d = ST_FRAME;
          cnt_d   = 16'd7;
        end else if (start_l4) begin
          state_d = ST_FRAME;
          cnt_d   = 16'd3;
        end
      end
      default: begin
        if (!any_ctrl) begin
          cnt_d = sat_add(cnt_q, 4'd8);
        end else begin
          report  = 1'b1;
          err_d   = !is_term;
          rep_cnt = sat_add(cnt_q, {1'b0, first_lane});
          if (restart) begin
            cnt_d = 16'd3;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
    endcase
    len_d  = (rep_cnt < 16'd7) ? 16'd0 : rep_cnt - 16'd7;
    runt_d = len_d < 16'(MIN_LEN);
    long_d = len_d > 16'(MAX_LEN);
  end

  assign inc = {5{report}} & {long_d, runt_d, err_d, !(err_d || runt_d || long_d), 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here is plain flops, so every register takes an explicit
    // reset value and every update uses <= to avoid ordering races between blocks.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
      runt_q  <= 1'b0;
      long_q  <= 1'b0;
      for (int i = 0; i < 5; i++) stat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= report;
      if (report) begin
        len_q  <= len_d;
        err_q  <= err_d;
        runt_q <= runt_d;
        long_q <= long_d;
      end
      for (int i = 0; i < 5; i++) begin
        if (clear)                       stat_q[i] <= '0;
        else if (inc[i] && ~&stat_q[i])  stat_q[i] <= stat_q[i] + COUNT_WIDTH'(1);
      end
    end
  end

  assign frame_valid = valid_q;
  assign frame_len   = len_q;
  assign frame_error = err_q;
  assign frame_runt  = runt_q;
  assign frame_long  = long_q;
  assign frame_count = stat_q[0];
  assign good_count  = stat_q[1];
  assign error_count = stat_q[2];
  assign runt_count  = stat_q[3];
  assign long_count  = stat_q[4];

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Directed self-checking bench for xgmii_rx_frame_checker.
module tb_xgmii_rx_frame_checker;
  import xgmii_rx_frame_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        frame_valid, frame_error, frame_runt, frame_long;
  logic [15:0] frame_len;
  logic [31:0] frame_count, good_count, error_count, runt_count, long_count;

  xgmii_rx_frame_checker dut (
    .clk         (clk),
    .rst         (rst),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .clear       (clear),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_error (frame_error),
    .frame_runt  (frame_runt),
    .frame_long  (frame_long),
    .frame_count (frame_count),
    .good_count  (good_count),
    .error_count (error_count),
    .runt_count  (runt_count),
    .long_count  (long_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] e_f = 0, e_g = 0, e_e = 0, e_r = 0, e_l = 0;

  // status = {valid, error, runt, long}; counters = {frame, good, error, runt, long}
  logic [3:0]   st;
  logic [159:0] cnts;
  assign st   = {frame_valid, frame_error, frame_runt, frame_long};
  assign cnts = {frame_count, good_count, error_count, runt_count, long_count};

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask

  task automatic idle_w();
    drive({8{CH_IDLE}}, 8'hFF);
  endtask

  task automatic sof0();
    drive(64'hD5555555555555FB, 8'h01);
  endtask

  task automatic sof4();
    drive(64'h555555FB07070707, 8'h1F);
  endtask

  task automatic data(input int n);
    repeat (n) drive(64'h1122334455667788, 8'h00);
  endtask

  // Ending word: data below lane p, character ch in lane p, idles above.
  task automatic eof(input int p, input logic [7:0] ch);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = (i < p) ? 8'hAA : (i == p) ? ch : CH_IDLE;
    drive(d, 8'(8'hFF << p));
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    xgmii_rxd = {8{CH_IDLE}}; xgmii_rxc = 8'hFF;
    repeat (2) @(negedge clk);
    n_cmp++; if (st !== 4'b0000) begin n_bad++; $display("FAIL reset_status got %b want 0000", st); end
    n_cmp++; if (frame_len !== 16'd0) begin n_bad++; $display("FAIL reset_len got %0d want 0", frame_len); end
    n_cmp++; if (cnts !== 160'd0) begin n_bad++; $display("FAIL reset_counters got %h want 0", cnts); end
    rst = 1'b0;
    idle_w();
  endtask

  task automatic test_good_64();
    sof0(); data(8); eof(0, CH_TERM);
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL good64_early got %b want 0", frame_valid); end
    idle_w();
    e_f++; e_g++;
    n_cmp++; if (st !== 4'b1000) begin n_bad++; $display("FAIL good64_status got %b want 1000", st); end
    n_cmp++; if (frame_len !== 16'd64) begin n_bad++; $display("FAIL good64_len got %0d want 64", frame_len); end
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL good64_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
    idle_w();
    n_cmp++; if (st !== 4'b0000 || frame_len !== 16'd64) begin n_bad++; $display("FAIL good64_hold got %b/%0d want 0000/64", st, frame_len); end
  endtask

  task automatic test_runt_lane4();
    sof4(); data(8); eof(0, CH_TERM); idle_w();
    e_f++; e_r++;
    n_cmp++; if (st !== 4'b1010) begin n_bad++; $display("FAIL runt_status got %b want 1010", st); end
    n_cmp++; if (frame_len !== 16'd60) begin n_bad++; $display("FAIL runt_len got %0d want 60", frame_len); end
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL runt_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_long();
    sof0(); data(200); eof(0, CH_TERM); idle_w();
    e_f++; e_l++;
    n_cmp++; if (st !== 4'b1001) begin n_bad++; $display("FAIL long_status got %b want 1001", st); end
    n_cmp++; if (frame_len !== 16'd1600) begin n_bad++; $display("FAIL long_len got %0d want 1600", frame_len); end
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL long_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_error();
    sof0(); data(3); eof(5, CH_ERROR); data(1);
    e_f++; e_e++; e_r++;
    n_cmp++; if (st !== 4'b1110) begin n_bad++; $display("FAIL error_status got %b want 1110", st); end
    n_cmp++; if (frame_len !== 16'd29) begin n_bad++; $display("FAIL error_len got %0d want 29", frame_len); end
    data(3); eof(0, CH_TERM); idle_w(); idle_w();
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL error_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_back_to_back();
    sof0(); data(8);
    drive(64'h555555FB0707FDAA, 8'h1E);
    data(1);
    e_f++; e_g++;
    n_cmp++; if (st !== 4'b1000 || frame_len !== 16'd65) begin n_bad++; $display("FAIL b2b_first got %b/%0d want 1000/65", st, frame_len); end
    data(7); eof(4, CH_TERM); idle_w();
    e_f++; e_g++;
    n_cmp++; if (st !== 4'b1000 || frame_len !== 16'd64) begin n_bad++; $display("FAIL b2b_second got %b/%0d want 1000/64", st, frame_len); end
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL b2b_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_boundaries();
    sof0(); data(189); eof(6, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1000 || frame_len !== 16'd1518) begin n_bad++; $display("FAIL max_len got %b/%0d want 1000/1518", st, frame_len); end
    sof0(); data(189); eof(7, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1001 || frame_len !== 16'd1519) begin n_bad++; $display("FAIL max_plus1 got %b/%0d want 1001/1519", st, frame_len); end
    sof0(); data(7); eof(7, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1010 || frame_len !== 16'd63) begin n_bad++; $display("FAIL min_minus1 got %b/%0d want 1010/63", st, frame_len); end
    sof4(); eof(0, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1010 || frame_len !== 16'd0) begin n_bad++; $display("FAIL len_floor got %b/%0d want 1010/0", st, frame_len); end
    drive(64'h555555FB070707FB, 8'h1F); data(8); eof(0, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1000 || frame_len !== 16'd64) begin n_bad++; $display("FAIL lane0_priority got %b/%0d want 1000/64", st, frame_len); end
    sof0(); data(8200); eof(3, CH_TERM); idle_w();
    n_cmp++; if (st !== 4'b1001 || frame_len !== 16'hFFF8) begin n_bad++; $display("FAIL len_saturate got %b/%h want 1001/fff8", st, frame_len); end
    e_f += 6; e_g += 2; e_l += 2; e_r += 2;
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL bound_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_reset_mid_frame();
    sof0(); data(3);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (st !== 4'b0000 || frame_len !== 16'd0 || cnts !== 160'd0) begin n_bad++; $display("FAIL rst_async got %b/%0d/%h want all 0", st, frame_len, cnts); end
    @(negedge clk); rst = 1'b0;
    e_f = 0; e_g = 0; e_e = 0; e_r = 0; e_l = 0;
    data(2); eof(0, CH_TERM); idle_w(); idle_w();
    n_cmp++; if (cnts !== 160'd0 || frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_discard got %h/%b want 0/0", cnts, frame_valid); end
    sof0(); data(8); eof(0, CH_TERM); idle_w();
    e_f++; e_g++;
    n_cmp++; if (st !== 4'b1000 || frame_len !== 16'd64) begin n_bad++; $display("FAIL rst_next_frame got %b/%0d want 1000/64", st, frame_len); end
    n_cmp++; if (cnts !== {e_f, e_g, e_e, e_r, e_l}) begin n_bad++; $display("FAIL rst_counters got %h want %h", cnts, {e_f, e_g, e_e, e_r, e_l}); end
  endtask

  task automatic test_clear();
    sof0(); data(8); eof(0, CH_TERM);
    clear = 1'b1;
    idle_w();
    clear = 1'b0;
    n_cmp++; if (st !== 4'b1000) begin n_bad++; $display("FAIL clear_report got %b want 1000", st); end
    n_cmp++; if (cnts !== 160'd0) begin n_bad++; $display("FAIL clear_counters got %h want 0", cnts); end
    sof0(); data(8); eof(0, CH_TERM); idle_w();
    n_cmp++; if (cnts !== {32'd1, 32'd1, 32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL clear_recount got %h want frame=good=1", cnts); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_64();
    test_runt_lane4();
    test_long();
    test_error();
    test_back_to_back();
    test_boundaries();
    test_reset_mid_frame();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
